mm_loop_addr_seq: RTL and testbench

- Parametrised successor to the core's fixed CI/CJ/CK + SI/SJ/SK + address-module datapath.
- Runs the i/j/k loop nest of D = A×B for one core and issues A, B and D data-memory addresses, one tuple per accepted step, under a valid/ready handshake.
- Supports runtime matrix dimensions, arbitrary base addresses, and row-interleaved work splitting across up to NUM_CORES cores.
- Sits between the control unit, which drives start/config and consumes tuples, and the DAR load path.

---
 rtl/mm_loop_addr_seq_pkg.sv | 20 ++
 rtl/mm_loop_addr_seq_if.sv | 26 ++
 rtl/mm_loop_addr_seq_counter.sv | 28 ++
 rtl/mm_loop_addr_seq.sv | 133 +++++++++++++
 tb/tb_mm_loop_addr_seq.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/mm_loop_addr_seq_pkg.sv
// Shared types and default sizing for the matrix-multiply loop/address sequencer.
package mm_pkg;
  localparam int ADDR_W_DEF    = 8;
  localparam int DIM_W_DEF     = 8;
  localparam int NUM_CORES_DEF = 4;
  localparam int CW_DEF        = $clog2(NUM_CORES_DEF) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [DIM_W_DEF-1:0]  dim_i;
    logic [DIM_W_DEF-1:0]  dim_k;
    logic [DIM_W_DEF-1:0]  dim_j;
    logic [ADDR_W_DEF-1:0] base_a;
    logic [ADDR_W_DEF-1:0] base_b;
    logic [ADDR_W_DEF-1:0] base_d;
    logic [CW_DEF-1:0]     core_id;
    logic [CW_DEF-1:0]     num_cores;
  } cfg_t;
endpackage

// File: rtl/mm_loop_addr_seq_if.sv
// Control-unit <-> sequencer bundle: start/config in, address tuples out under valid/ready.
interface mm_loop_addr_seq_if #(
  parameter int ADDR_W    = 8,
  parameter int DIM_W     = 8,
  parameter int NUM_CORES = 4
);
  localparam int CW = $clog2(NUM_CORES) + 1;

  logic              start;
  logic [DIM_W-1:0]  dim_i, dim_k, dim_j;
  logic [ADDR_W-1:0] base_a, base_b, base_d;
  logic [CW-1:0]     core_id, num_cores;
  logic              addr_valid, addr_ready;
  logic [ADDR_W-1:0] addr_a, addr_b, addr_d;
  logic              first_k, last_k, busy, done;

  modport master (
    output start, dim_i, dim_k, dim_j, base_a, base_b, base_d, core_id, num_cores, addr_ready,
    input  addr_valid, addr_a, addr_b, addr_d, first_k, last_k, busy, done
  );

  modport slave (
    input  start, dim_i, dim_k, dim_j, base_a, base_b, base_d, core_id, num_cores, addr_ready,
    output addr_valid, addr_a, addr_b, addr_d, first_k, last_k, busy, done
  );
endinterface

// File: rtl/mm_loop_addr_seq_counter.sv
// Loadable loop counter; o_wrap flags that the next step would reach the limit.
module mm_loop_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  input  logic [W-1:0] i_step,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);
  logic [W-1:0] r_cnt;
  logic [W:0]   w_sum;

  // One extra bit so cnt+step never aliases back below the limit.
  assign w_sum  = {1'b0, r_cnt} + {1'b0, i_step};
  assign o_wrap = (w_sum >= {1'b0, i_limit});
  assign o_cnt  = r_cnt;

  always_ff @(posedge clk) begin
    if (rst)         r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_inc)  r_cnt <= o_wrap ? '0 : w_sum[W-1:0];
  end
endmodule

// File: rtl/mm_loop_addr_seq.sv
// i/j/k loop nest for D = A x B on one core; emits A/B/D address tuples incrementally.
module mm_loop_addr_seq
  import mm_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DIM_W     = DIM_W_DEF,
  parameter int NUM_CORES = NUM_CORES_DEF
) (
  input logic               clock,
  input logic               RST,
  mm_loop_addr_seq_if.slave bus
);
  localparam int CW = $clog2(NUM_CORES) + 1;

  state_t            r_state, w_state_nxt;
  cfg_t              r_cfg;
  logic [CW-1:0]     w_core_id, w_ncores;
  logic [DIM_W-1:0]  w_i, w_j, w_k;
  logic              w_i_wrap, w_j_wrap, w_k_wrap;
  logic              w_start, w_empty, w_load, w_acc, w_last;
  logic [ADDR_W-1:0] r_a_ptr, r_b_ptr, r_d_ptr, r_row_a, r_row_d, r_stride_a, r_stride_d;
  logic [ADDR_W-1:0] w_ofs_a, w_ofs_d;
  logic              w_unused;

  assign w_core_id = bus.core_id;
  assign w_ncores  = bus.num_cores;
  assign w_start   = (r_state == IDLE) && bus.start;
  assign w_empty   = (bus.dim_i == '0) || (bus.dim_k == '0) || (bus.dim_j == '0) ||
                     (w_ncores == '0) || (DIM_W'(w_core_id) >= bus.dim_i);
  assign w_load    = w_start && !w_empty;
  assign w_acc     = (r_state == RUN) && bus.addr_ready;
  assign w_last    = w_k_wrap && w_j_wrap && w_i_wrap;

  // Start-time offsets only; the stepping path below is add-only.
  assign w_ofs_a = ADDR_W'(w_core_id) * ADDR_W'(bus.dim_k);
  assign w_ofs_d = ADDR_W'(w_core_id) * ADDR_W'(bus.dim_j);

  mm_loop_counter #(.W(DIM_W)) u_cnt_k (
    .clk(clock), .rst(RST), .i_load(w_start), .i_load_val('0),
    .i_inc(w_acc), .i_step(DIM_W'(1)), .i_limit(r_cfg.dim_k),
    .o_cnt(w_k), .o_wrap(w_k_wrap)
  );

  mm_loop_counter #(.W(DIM_W)) u_cnt_j (
    .clk(clock), .rst(RST), .i_load(w_start), .i_load_val('0),
    .i_inc(w_acc && w_k_wrap), .i_step(DIM_W'(1)), .i_limit(r_cfg.dim_j),
    .o_cnt(w_j), .o_wrap(w_j_wrap)
  );

  mm_loop_counter #(.W(DIM_W)) u_cnt_i (
    .clk(clock), .rst(RST), .i_load(w_start), .i_load_val(DIM_W'(w_core_id)),
    .i_inc(w_acc && w_k_wrap && w_j_wrap), .i_step(DIM_W'(r_cfg.num_cores)),
    .i_limit(r_cfg.dim_i), .o_cnt(w_i), .o_wrap(w_i_wrap)
  );

  always_ff @(posedge clock) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    bus.addr_valid = 1'b0;
    bus.busy       = 1'b1;
    bus.done       = 1'b0;
    case (r_state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) w_state_nxt = w_empty ? DONE : RUN;
      end
      RUN: begin
        bus.addr_valid = 1'b1;
        if (w_acc && w_last) w_state_nxt = DONE;
      end
      DONE: begin
        bus.done    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (RST) begin
      r_cfg      <= '0;
      r_a_ptr    <= '0;
      r_b_ptr    <= '0;
      r_d_ptr    <= '0;
      r_row_a    <= '0;
      r_row_d    <= '0;
      r_stride_a <= '0;
      r_stride_d <= '0;
    end else begin
      if (w_start)
        r_cfg <= '{dim_i: bus.dim_i, dim_k: bus.dim_k, dim_j: bus.dim_j,
                   base_a: bus.base_a, base_b: bus.base_b, base_d: bus.base_d,
                   core_id: bus.core_id, num_cores: bus.num_cores};
      if (w_load) begin
        r_stride_a <= ADDR_W'(w_ncores) * ADDR_W'(bus.dim_k);
        r_stride_d <= ADDR_W'(w_ncores) * ADDR_W'(bus.dim_j);
        r_row_a    <= bus.base_a + w_ofs_a;
        r_a_ptr    <= bus.base_a + w_ofs_a;
        r_b_ptr    <= bus.base_b;
        r_row_d    <= bus.base_d + w_ofs_d;
        r_d_ptr    <= bus.base_d + w_ofs_d;
      end else if (w_acc) begin
        if (!w_k_wrap) begin
          r_a_ptr <= r_a_ptr + ADDR_W'(1);
          r_b_ptr <= r_b_ptr + ADDR_W'(r_cfg.dim_j);
        end else if (!w_j_wrap) begin
          r_a_ptr <= r_row_a;
          r_b_ptr <= r_cfg.base_b + ADDR_W'(w_j) + ADDR_W'(1);
          r_d_ptr <= r_d_ptr + ADDR_W'(1);
        end else if (!w_i_wrap) begin
          r_row_a <= r_row_a + r_stride_a;
          r_a_ptr <= r_row_a + r_stride_a;
          r_b_ptr <= r_cfg.base_b;
          r_row_d <= r_row_d + r_stride_d;
          r_d_ptr <= r_row_d + r_stride_d;
        end
      end
    end
  end

  assign bus.addr_a  = r_a_ptr;
  assign bus.addr_b  = r_b_ptr;
  assign bus.addr_d  = r_d_ptr;
  assign bus.first_k = (r_state == RUN) && (w_k == '0);
  assign bus.last_k  = (r_state == RUN) && w_k_wrap;

  // i itself and some latched fields are never read back; kept for observability.
  assign w_unused = &{1'b0, w_i, r_cfg.base_a, r_cfg.base_d, r_cfg.core_id};
endmodule

// File: tb/tb_mm_loop_addr_seq.sv
// Randomized bench for mm_loop_addr_seq against a nested-loop reference model.
module tb_mm_loop_addr_seq;
  import mm_pkg::*;

  typedef struct {
    logic [7:0] a, b, d;
    logic       first, last;
  } tup_t;

  logic clock = 1'b0;
  logic RST;
  int   n_checks = 0;
  int   n_errors = 0;
  tup_t exp_q[$];

  mm_loop_addr_seq_if #(.ADDR_W(8), .DIM_W(8), .NUM_CORES(4)) bus ();

  mm_loop_addr_seq #(.ADDR_W(8), .DIM_W(8), .NUM_CORES(4)) dut (
    .clock(clock), .RST(RST), .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, act, exp);
    end
  endtask

  function automatic cfg_t mk_cfg(input int di, dk, dj, ba, bb, bd, core, nc);
    cfg_t c;
    c.dim_i = 8'(di); c.dim_k = 8'(dk); c.dim_j = 8'(dj);
    c.base_a = 8'(ba); c.base_b = 8'(bb); c.base_d = 8'(bd);
    c.core_id = 3'(core); c.num_cores = 3'(nc);
    return c;
  endfunction

  task automatic set_cfg(input cfg_t c);
    bus.dim_i = c.dim_i; bus.dim_k = c.dim_k; bus.dim_j = c.dim_j;
    bus.base_a = c.base_a; bus.base_b = c.base_b; bus.base_d = c.base_d;
    bus.core_id = c.core_id; bus.num_cores = c.num_cores;
  endtask

  // Reference: the plain loop nest with full multiplies, reduced mod 256.
  function automatic void build(input cfg_t c);
    int di, dk, dj;
    di = int'(c.dim_i); dk = int'(c.dim_k); dj = int'(c.dim_j);
    exp_q.delete();
    if (c.num_cores == 0) return;
    for (int i = int'(c.core_id); i < di; i += int'(c.num_cores))
      for (int j = 0; j < dj; j++)
        for (int k = 0; k < dk; k++) begin
          tup_t t;
          t.a = 8'((int'(c.base_a) + i * dk + k) % 256);
          t.b = 8'((int'(c.base_b) + k * dj + j) % 256);
          t.d = 8'((int'(c.base_d) + i * dj + j) % 256);
          t.first = (k == 0);
          t.last  = (k == dk - 1);
          exp_q.push_back(t);
        end
  endfunction

  // mode: 0 ready=1, 1 random ready, 2 stall 3 cycles at tuple 3, 3 stray start mid-run.
  // rst_at >= 0 aborts with RST while that tuple index is presented.
  task automatic run(input cfg_t c, input int mode, input int rst_at);
    int idx = 0, stall = 0, cyc = 0;
    bit rdy, exp_done = 0, poked = 0;
    build(c);
    set_cfg(c);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    if (exp_q.size() == 0) begin
      chk("empty_done", bus.done, 1);
      chk("empty_vld", bus.addr_valid, 0);
      @(negedge clock);
      chk("empty_idle", {bus.busy, bus.done, bus.addr_valid}, 0);
      return;
    end
    forever begin
      if (cyc > 2000) begin
        n_checks++; n_errors++;
        $display("FAIL timeout @%0t: no done after %0d cycles", $time, cyc);
        return;
      end
      if (exp_done) begin
        chk("done", bus.done, 1);
        chk("done_vld", bus.addr_valid, 0);
        @(negedge clock);
        chk("post_done", {bus.busy, bus.done}, 0);
        return;
      end
      chk("vld", bus.addr_valid, 1);
      chk("busy", bus.busy, 1);
      chk("no_early_done", bus.done, 0);
      chk("addr_a", bus.addr_a, exp_q[0].a);
      chk("addr_b", bus.addr_b, exp_q[0].b);
      chk("addr_d", bus.addr_d, exp_q[0].d);
      chk("first_k", bus.first_k, exp_q[0].first);
      chk("last_k", bus.last_k, exp_q[0].last);
      case (mode)
        1:       rdy = ($urandom_range(0, 3) != 0);
        2:       rdy = !(idx == 2 && stall < 3);
        default: rdy = 1'b1;
      endcase
      if (mode == 2 && !rdy) stall++;
      if (rst_at >= 0 && idx == rst_at) begin
        RST = 1'b1;
        bus.addr_ready = 1'b1;
        @(negedge clock);
        RST = 1'b0;
        chk("rst_vld", bus.addr_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_flags", {bus.done, bus.first_k, bus.last_k}, 0);
        chk("rst_addr", {bus.addr_a, bus.addr_b, bus.addr_d}, 0);
        repeat (3) begin
          @(negedge clock);
          chk("rst_no_done", {bus.done, bus.busy}, 0);
        end
        return;
      end
      if (mode == 3 && idx == 2 && !poked) begin
        poked = 1;
        bus.start = 1'b1;
        set_cfg(mk_cfg(1, 1, 1, 0, 0, 0, 0, 1));
      end
      bus.addr_ready = rdy;
      @(negedge clock);
      bus.start = 1'b0;
      cyc++;
      if (rdy) begin
        void'(exp_q.pop_front());
        idx++;
        if (exp_q.size() == 0) exp_done = 1;
      end
    end
  endtask

  initial begin
    cfg_t s1;
    RST = 1'b1;
    bus.start = 1'b0;
    bus.addr_ready = 1'b0;
    set_cfg(mk_cfg(0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(negedge clock);
    chk("reset_vld", bus.addr_valid, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_flags", {bus.done, bus.first_k, bus.last_k}, 0);
    chk("reset_addr", {bus.addr_a, bus.addr_b, bus.addr_d}, 0);
    RST = 1'b0;
    @(negedge clock);

    s1 = mk_cfg(2, 2, 2, 0, 4, 8, 0, 1);
    run(s1, 0, -1);
    run(mk_cfg(3, 1, 1, 'h10, 'h20, 'h30, 1, 2), 0, -1);
    run(mk_cfg(3, 1, 1, 'h10, 'h20, 'h30, 0, 2), 0, -1);
    run(s1, 2, -1);
    run(mk_cfg(2, 0, 2, 0, 4, 8, 0, 1), 0, -1);
    run(mk_cfg(2, 2, 2, 0, 4, 8, 3, 4), 0, -1);
    run(s1, 3, -1);
    run(mk_cfg(2, 1, 4, 0, 0, 250, 0, 1), 0, -1);
    run(s1, 0, 3);
    run(s1, 0, -1);

    for (int n = 0; n < 25; n++) begin
      int nc, core;
      nc = $urandom_range(1, 4);
      core = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4) : $urandom_range(0, nc - 1);
      run(mk_cfg($urandom_range(1, 5), $urandom_range(1, 4), $urandom_range(1, 4),
                 $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                 core, nc), 1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
